dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Multi-cycle data-memory responder on the far side of the pipeline MEM-stage load/store interface (MemRead, MemWrite, addr, wr_data, func3 -> rd_data).
- Accepts one load or store and performs RISC-V byte, halfword and word accesses.
- Returns extended load data after a programmable latency.
- Raises stall toward the pipeline while an access is in flight.
- Replaces the single-cycle datamemory once memory latency is made realistic.

Parameters:
DM_ADDRESS, 9, byte-address width; the array holds 2^(DM_ADDRESS-2) 32-bit words.
DATA_W, 32, data width; fixed at 32.
LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
MemRead  input  1  load request.
MemWrite  input  1  store request.
addr  input  DM_ADDRESS  byte address.
wr_data  input  DATA_W  store data, right-aligned.
func3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
rd_data  output  DATA_W  extended load data, registered.
rd_valid  output  1  one-cycle pulse when rd_data is valid for a load.
stall  output  1  pipeline must hold MEM stage and inputs stable.
err  output  1  one-cycle pulse for misaligned access or illegal func3.

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, rd_data=0, rd_valid=0, err=0, wait counter=0.
  - stall is 0 during reset.
  - Memory array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req = MemRead | MemWrite.
  - On req: capture addr, wr_data, func3 and op. MemWrite has priority if both are high; the access is then treated as a store.
  - Next state is WAIT with counter=LATENCY-1, or RESP directly if LATENCY==1.
  - stall = req, combinational in the acceptance cycle.
- WAIT:
  - stall=1.
  - Counter decrements each cycle; at counter==1 the next state is RESP.
  - Inputs are ignored; captured values are used.
- RESP (exactly one cycle):
  - stall=0.
  - For a legal load, rd_valid=1 and rd_data holds the result.
  - For an error, err=1 and rd_data=0.
  - Inputs are ignored; next state is IDLE.
  - A new request is sampled only in the following IDLE cycle.
- Timing: request seen in IDLE at cycle t -> RESP at cycle t+LATENCY. stall is high for cycles t..t+LATENCY-1.
- Store commit: the array write happens on the clock edge entering RESP.
  - sb writes byte lane addr[1:0] from wr_data[7:0].
  - sh writes lanes {addr[1],0},{addr[1],1} from wr_data[15:0].
  - sw writes the full word.
  - Other lanes are preserved.
- Load: the word at addr[DM_ADDRESS-1:2] is read and the lane selected by addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - rd_data is loaded on the edge entering RESP and holds its value until the next load response or reset.
- Errors:
  - Conditions: halfword with addr[0]=1; word with addr[1:0]!=0; func3 in {011,110,111}; store func3 not in {000,001,010}.
  - Effect: no array write, rd_valid=0, err=1 in RESP, same latency as a legal access.
- Reset mid-operation: FSM returns to IDLE immediately and stall drops. An uncommitted store is discarded; a store already committed remains.
- rd_valid and err are never both 1. Both are 0 outside RESP.

Test Plan:
- sw 0xDEADBEEF @0x010, then lw @0x010 (LATENCY=2) -> stall high 2 cycles per access; rd_valid pulses in the cycle after the second stall cycle; rd_data=0xDEADBEEF.
- sb 0x80 @0x013 over the word above, then lb @0x013 -> 0xFFFFFF80; lbu @0x013 -> 0x00000080; lw @0x010 -> 0x80ADBEEF.
- sh 0x8001 @0x022, then lh @0x022 -> 0xFFFF8001; lhu -> 0x00008001; lw @0x020 -> 0x8001xxxx with the low half unchanged.
- lw @0x011, sh @0x021 and func3=011 -> err pulse in RESP, rd_valid=0, rd_data=0; memory at 0x020 is unchanged.
- MemRead and MemWrite both high, sw 0x12345678 @0x030 -> treated as store, no rd_valid; a following lw returns 0x12345678.
- reset asserted during WAIT of sw @0x040 -> stall=0 asynchronously, state IDLE; a following lw @0x040 returns the prior contents. Repeat at LATENCY=1: stall high only in the acceptance cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle RISC-V data memory: one load/store at a time, response LATENCY cycles after acceptance.
// Backpressure: stall is high from the acceptance cycle until the cycle before the response.
module dmem_responder #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            func3,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  stall,
   output logic                  err
);

   localparam int         WORDS  = 1 << (DM_ADDRESS - 2);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt;
   logic                  cap_store;
   logic [DM_ADDRESS-1:0] cap_addr;
   logic [DATA_W-1:0]     cap_wdata;
   logic [2:0]            cap_func3;

   logic                  req;
   logic                  in_idle;
   logic                  enter_resp;
   logic                  cur_store;
   logic [DM_ADDRESS-1:0] cur_addr;
   logic [DATA_W-1:0]     cur_wdata;
   logic [2:0]            cur_func3;
   logic                  acc_err;

   logic [DATA_W-1:0]     mem [WORDS];
   logic [DATA_W-1:0]     word_rd;
   logic [DATA_W-1:0]     merged;
   logic [DATA_W-1:0]     load_val;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;

   // Requests seen while reset is held must neither stall nor reach the array.
   assign req        = (MemRead | MemWrite) & ~reset;
   assign in_idle    = (state == IDLE);
   assign enter_resp = (state_nxt == RESP);

   // With LATENCY==1 the access completes on the acceptance edge, before capture.
   assign cur_store = in_idle ? MemWrite : cap_store;
   assign cur_addr  = in_idle ? addr     : cap_addr;
   assign cur_wdata = in_idle ? wr_data  : cap_wdata;
   assign cur_func3 = in_idle ? func3    : cap_func3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT:    if (cnt == 4'd1) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:    stall = req;
         WAIT:    stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   always_comb begin
      acc_err = 1'b0;
      case (cur_func3)
         3'b000, 3'b100: acc_err = 1'b0;
         3'b001, 3'b101: acc_err = cur_addr[0];
         3'b010:         acc_err = |cur_addr[1:0];
         default:        acc_err = 1'b1;
      endcase
      if (cur_store && cur_func3[2]) acc_err = 1'b1;
   end

   assign word_rd = mem[cur_addr[DM_ADDRESS-1:2]];

   always_comb begin
      byte_sel = word_rd[{cur_addr[1:0], 3'b000} +: 8];
      half_sel = word_rd[{cur_addr[1], 4'b0000} +: 16];
      case (cur_func3)
         3'b000:  load_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         3'b100:  load_val = {{(DATA_W-8){1'b0}}, byte_sel};
         3'b001:  load_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
         3'b101:  load_val = {{(DATA_W-16){1'b0}}, half_sel};
         default: load_val = word_rd;
      endcase
   end

   always_comb begin
      merged = word_rd;
      case (cur_func3[1:0])
         2'b00:   merged[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
         2'b01:   merged[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
         default: merged = cur_wdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (enter_resp && cur_store && !acc_err)
         mem[cur_addr[DM_ADDRESS-1:2]] <= merged;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= 4'd0;
         cap_store <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_func3 <= 3'b000;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         err       <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         err      <= 1'b0;
         if (in_idle && req) begin
            cap_store <= MemWrite;
            cap_addr  <= addr;
            cap_wdata <= wr_data;
            cap_func3 <= func3;
            cnt       <= LAT_M1;
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            if (acc_err) begin
               err     <= 1'b1;
               rd_data <= '0;
            end else if (!cur_store) begin
               rd_valid <= 1'b1;
               rd_data  <= load_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY=2 (dut2) and LATENCY=1 (dut1) against a word-array model.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2] = '{1'b1, 1'b1};
   logic        mrd [2] = '{1'b0, 1'b0};
   logic        mwr [2] = '{1'b0, 1'b0};
   logic [8:0]  a   [2] = '{9'h0, 9'h0};
   logic [31:0] wd  [2] = '{32'h0, 32'h0};
   logic [2:0]  f3  [2] = '{3'b0, 3'b0};
   logic [31:0] rdd [2];
   logic        rv  [2];
   logic        st  [2];
   logic        er  [2];

   dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(2)) dut2 (
      .clk(clk), .reset(rst[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]), .addr(a[0]),
      .wr_data(wd[0]), .func3(f3[0]), .rd_data(rdd[0]), .rd_valid(rv[0]), .stall(st[0]), .err(er[0]));

   dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(1)) dut1 (
      .clk(clk), .reset(rst[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]), .addr(a[1]),
      .wr_data(wd[1]), .func3(f3[1]), .rd_data(rdd[1]), .rd_valid(rv[1]), .stall(st[1]), .err(er[1]));

   localparam bit LD = 1'b0;
   localparam bit ST = 1'b1;

   // Model: array contents, plus the one access in flight (kind 0=store, 1=load, 2=error).
   logic [31:0] mdl      [2][128];
   int          acc_cyc  [2] = '{-100, -100};
   int          resp_cyc [2] = '{-100, -100};
   int          kind     [2] = '{0, 0};
   logic [31:0] exp_data [2] = '{32'h0, 32'h0};
   logic [31:0] held     [2] = '{32'h0, 32'h0};

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, lat_of(d), cyc, act, exp);
      end
   endtask

   function automatic void model_access(input int d, input bit is_st, input logic [2:0] fn,
                                        input logic [8:0] ad, input logic [31:0] w,
                                        output int k, output logic [31:0] res);
      int          size;
      int          off;
      logic [31:0] word;
      logic [31:0] mask;
      case (fn)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      off  = int'(ad) % 4;
      word = mdl[d][int'(ad) / 4];
      res  = 32'h0;
      k    = 0;
      if (size == 0 || (off % size) != 0 || (is_st && fn > 3'd2)) begin
         k = 2;
      end else if (is_st) begin
         mask = (size == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * size)) - 32'd1) << (8 * off));
         mdl[d][int'(ad) / 4] = (word & ~mask) | ((w << (8 * off)) & mask);
      end else begin
         k   = 1;
         res = word >> (8 * off);
         if (size == 1) begin
            res = res & 32'hFF;
            if (fn == 3'd0 && res >= 32'h80) res = res | 32'hFFFF_FF00;
         end else if (size == 2) begin
            res = res & 32'hFFFF;
            if (fn == 3'd1 && res >= 32'h8000) res = res | 32'hFFFF_0000;
         end
      end
   endfunction

   always @(negedge clk) begin
      logic e_st, e_rv, e_er;
      for (int d = 0; d < 2; d++) begin
         if (rst[d]) begin
            e_st = 1'b0; e_rv = 1'b0; e_er = 1'b0;
         end else begin
            e_st = (cyc >= acc_cyc[d]) && (cyc < acc_cyc[d] + lat_of(d));
            e_rv = (cyc == resp_cyc[d]) && (kind[d] == 1);
            e_er = (cyc == resp_cyc[d]) && (kind[d] == 2);
            if (cyc == resp_cyc[d] && kind[d] != 0) held[d] = exp_data[d];
         end
         chk("stall",    d, 32'(st[d]), 32'(e_st));
         chk("rd_valid", d, 32'(rv[d]), 32'(e_rv));
         chk("err",      d, 32'(er[d]), 32'(e_er));
         chk("rd_data",  d, rdd[d], held[d]);
      end
   end

   // Call at #1 after a posedge in an IDLE cycle; returns at #1 after a posedge in the next IDLE cycle.
   task automatic access(input int d, input bit is_st, input bit both, input logic [2:0] fn,
                         input logic [8:0] ad, input logic [31:0] w,
                         input bit chk_lit, input logic [31:0] lit, input string nm);
      mrd[d] = !is_st || both;
      mwr[d] = is_st;
      a[d]   = ad;
      wd[d]  = w;
      f3[d]  = fn;
      model_access(d, is_st, fn, ad, w, kind[d], exp_data[d]);
      acc_cyc[d]  = cyc;
      resp_cyc[d] = cyc + lat_of(d);
      // Scramble the request fields after acceptance; the DUT must use its captured copy.
      for (int i = 0; i < lat_of(d); i++) begin
         @(posedge clk); #1;
         a[d]  = ~ad;
         wd[d] = ~w;
         f3[d] = ~fn;
      end
      mrd[d] = 1'b0;
      mwr[d] = 1'b0;
      if (chk_lit) begin
         @(negedge clk);
         chk(nm, d, rdd[d], lit);
      end
      @(posedge clk); #1;
   endtask

   // Word store interrupted by reset after wait_cycles cycles; the write must be discarded.
   task automatic store_with_reset(input int d, input logic [8:0] ad, input logic [31:0] w,
                                   input int wait_cycles);
      mrd[d] = 1'b0;
      mwr[d] = 1'b1;
      a[d]   = ad;
      wd[d]  = w;
      f3[d]  = 3'b010;
      kind[d]     = 0;
      acc_cyc[d]  = cyc;
      resp_cyc[d] = cyc + lat_of(d);
      repeat (wait_cycles) begin
         @(posedge clk); #1;
      end
      #1;
      rst[d]      = 1'b1;
      acc_cyc[d]  = -100;
      resp_cyc[d] = -100;
      held[d]     = 32'h0;
      #1;
      chk("stall_async_reset", d, 32'(st[d]), 32'h0);
      @(posedge clk); #1;
      rst[d] = 1'b0;
      mwr[d] = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      access(0, ST, 0, 3'b010, 9'h010, 32'hDEADBEEF, 0, 32'h0,        "");
      access(0, LD, 0, 3'b010, 9'h010, 32'h0,        1, 32'hDEADBEEF, "lw_010");
      access(0, ST, 0, 3'b000, 9'h013, 32'h00000080, 0, 32'h0,        "");
      access(0, LD, 0, 3'b000, 9'h013, 32'h0,        1, 32'hFFFFFF80, "lb_013");
      access(0, LD, 0, 3'b100, 9'h013, 32'h0,        1, 32'h00000080, "lbu_013");
      access(0, LD, 0, 3'b010, 9'h010, 32'h0,        1, 32'h80ADBEEF, "lw_010_after_sb");
      access(0, LD, 0, 3'b000, 9'h010, 32'h0,        1, 32'hFFFFFFEF, "lb_010");
      access(0, ST, 0, 3'b010, 9'h020, 32'h1111CAFE, 0, 32'h0,        "");
      access(0, ST, 0, 3'b001, 9'h022, 32'h00008001, 0, 32'h0,        "");
      access(0, LD, 0, 3'b001, 9'h022, 32'h0,        1, 32'hFFFF8001, "lh_022");
      access(0, LD, 0, 3'b101, 9'h022, 32'h0,        1, 32'h00008001, "lhu_022");
      access(0, LD, 0, 3'b010, 9'h020, 32'h0,        1, 32'h8001CAFE, "lw_020");
      access(0, LD, 0, 3'b001, 9'h020, 32'h0,        1, 32'hFFFFCAFE, "lh_020");
      access(0, LD, 0, 3'b010, 9'h011, 32'h0,        1, 32'h00000000, "err_lw_011");
      access(0, ST, 0, 3'b001, 9'h021, 32'h00005555, 1, 32'h00000000, "err_sh_021");
      access(0, LD, 0, 3'b011, 9'h020, 32'h0,        1, 32'h00000000, "err_f3_011");
      access(0, ST, 0, 3'b100, 9'h020, 32'h000000AA, 1, 32'h00000000, "err_store_f3_100");
      access(0, LD, 0, 3'b010, 9'h020, 32'h0,        1, 32'h8001CAFE, "lw_020_after_errs");
      access(0, ST, 1, 3'b010, 9'h030, 32'h12345678, 0, 32'h0,        "");
      access(0, LD, 0, 3'b010, 9'h030, 32'h0,        1, 32'h12345678, "lw_030_both");
      access(0, ST, 0, 3'b010, 9'h040, 32'hA5A5A5A5, 0, 32'h0,        "");
      store_with_reset(0, 9'h040, 32'h0BADF00D, 1);
      access(0, LD, 0, 3'b010, 9'h040, 32'h0,        1, 32'hA5A5A5A5, "lw_040_after_reset");

      access(1, ST, 0, 3'b010, 9'h010, 32'hDEADBEEF, 0, 32'h0,        "");
      access(1, LD, 0, 3'b010, 9'h010, 32'h0,        1, 32'hDEADBEEF, "l1_lw_010");
      access(1, ST, 0, 3'b000, 9'h011, 32'h0000007F, 0, 32'h0,        "");
      access(1, LD, 0, 3'b000, 9'h011, 32'h0,        1, 32'h0000007F, "l1_lb_011");
      access(1, LD, 0, 3'b010, 9'h010, 32'h0,        1, 32'hDEAD7FEF, "l1_lw_010_after_sb");
      access(1, LD, 0, 3'b101, 9'h012, 32'h0,        1, 32'h0000DEAD, "l1_lhu_012");
      access(1, LD, 0, 3'b010, 9'h012, 32'h0,        1, 32'h00000000, "l1_err_lw_012");
      access(1, ST, 0, 3'b010, 9'h040, 32'hA5A5A5A5, 0, 32'h0,        "");
      store_with_reset(1, 9'h040, 32'h0BADF00D, 0);
      access(1, LD, 0, 3'b010, 9'h040, 32'h0,        1, 32'hA5A5A5A5, "l1_lw_040_after_reset");

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
